// File: rtl/opc_board_pkg.sv
// opc_board_pkg: shared constants and elaboration helpers for the OPC board-glue block.
//   PWM_BITS     width of the LED dimming counter
//   ms_prescale  clock cycles per millisecond for a given clock frequency
//   cnt_width    bits needed to hold the values 0..n (never less than 1)
package opc_board_pkg;

   localparam int unsigned PWM_BITS = 4;

   function automatic int unsigned ms_prescale(input int unsigned clkspeed);
      return clkspeed / 1000;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/opc_debounce.sv
// opc_debounce: one switch channel. Two-flop synchroniser, millisecond debounce counter,
// accepted state and a one-cycle change pulse.
// Ports:
//   clk      system clock
//   reset_b  asynchronous active-low reset
//   tick_ms  shared one-cycle pulse every millisecond
//   pin      raw switch pin, asynchronous to clk
//   state    debounced switch state
//   changed  one-cycle pulse in the cycle state changes
module opc_debounce
   import opc_board_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS = 10
) (
   input  logic clk,
   input  logic reset_b,
   input  logic tick_ms,
   input  logic pin,
   output logic state,
   output logic changed
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_MS);
   // Count value whose next tick completes the debounce window.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

   logic          meta_q;
   logic          sync_q;
   logic          state_q, state_d;
   logic          changed_q, changed_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      changed_d = 1'b0;
      cnt_d     = cnt_q;
      if (sync_q == state_q) begin
         // Agreement (including a bounce back) discards any partial window.
         cnt_d = '0;
      end else if (tick_ms) begin
         if (cnt_q == CNT_LAST) begin
            state_d   = sync_q;
            changed_d = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         meta_q    <= 1'b0;
         sync_q    <= 1'b0;
         state_q   <= 1'b0;
         changed_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         meta_q    <= pin;
         sync_q    <= meta_q;
         state_q   <= state_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
      end
   end

   assign state   = state_q;
   assign changed = changed_q;

endmodule

// File: rtl/opc_board_io.sv
// opc_board_io: board glue between FPGA pins and an OPC core.
//   - stretched, synchronously released core reset from reset_b and btn_reset
//   - 1 ms prescaler (tick_ms)
//   - NUM_SW debounced switches with per-channel change pulses
//   - registered LED drive, optionally PWM-dimmed when OPC_BOARD_PWM_EN is defined
// Ports:
//   clk          system clock (CLKSPEED Hz)
//   reset_b      asynchronous active-low board reset
//   btn_reset    raw active-high reset button, asynchronous to clk
//   sw_i/sw_o    raw switch pins / debounced switch state
//   sw_changed   one-cycle pulse per channel when sw_o changes
//   led_i/led_o  LED request from core / LED pin drive (1-cycle latency)
//   sys_reset_b  active-low core reset, asynchronous assert, synchronous release
//   tick_ms      one-cycle pulse every millisecond
// Build macro: OPC_BOARD_PWM_EN enables LED dimming with on-time (LED_DUTY+1)/16.
module opc_board_io
   import opc_board_pkg::*;
#(
   parameter int unsigned CLKSPEED     = 40000000,
   parameter int unsigned NUM_SW       = 8,
   parameter int unsigned NUM_LED      = 8,
   parameter int unsigned DEBOUNCE_MS  = 10,
   parameter int unsigned RESET_CYCLES = 16,
   parameter int unsigned LED_DUTY     = 7
) (
   input  logic               clk,
   input  logic               reset_b,
   input  logic               btn_reset,
   input  logic [NUM_SW-1:0]  sw_i,
   output logic [NUM_SW-1:0]  sw_o,
   output logic [NUM_SW-1:0]  sw_changed,
   input  logic [NUM_LED-1:0] led_i,
   output logic [NUM_LED-1:0] led_o,
   output logic               sys_reset_b,
   output logic               tick_ms
);

   localparam int unsigned PRESCALE = ms_prescale(CLKSPEED);
   localparam int unsigned PW       = cnt_width(PRESCALE - 1);
   localparam int unsigned RW       = cnt_width(RESET_CYCLES);

   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [RW-1:0] HOLD_MAX = RW'(RESET_CYCLES);

   // Parameter sanity checks.
   if (CLKSPEED < 2000 || (CLKSPEED % 1000) != 0) begin : g_bad_clkspeed
      $error("CLKSPEED must be a multiple of 1000 and at least 2000");
   end
   if (NUM_SW < 1 || NUM_SW > 32 || NUM_LED < 1 || NUM_LED > 32) begin : g_bad_width
      $error("NUM_SW and NUM_LED must be in 1..32");
   end
   if (DEBOUNCE_MS < 1 || RESET_CYCLES < 1) begin : g_bad_timing
      $error("DEBOUNCE_MS and RESET_CYCLES must be at least 1");
   end
   if (LED_DUTY >= (1 << PWM_BITS)) begin : g_bad_duty
      $error("LED_DUTY must be in 0..15");
   end

   // ---------------------------------------------------------------------------------------
   // Reset generator
   // ---------------------------------------------------------------------------------------
   logic          btn_meta_q;
   logic          btn_sync_q;
   logic          released_q;
   logic [RW-1:0] hold_q;

   // released_q samples the removal of reset_b so that counting starts one cycle after
   // the pin is seen high, matching the button path's pipeline.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         released_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         btn_meta_q <= btn_reset;
         btn_sync_q <= btn_meta_q;
         released_q <= 1'b1;
         if (btn_sync_q || !released_q) begin
            hold_q <= '0;
         end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + RW'(1);
         end
      end
   end

   // Decoded straight from the counter so a reset source pulls it low without waiting
   // for a further register stage.
   assign sys_reset_b = (hold_q == HOLD_MAX);

   // ---------------------------------------------------------------------------------------
   // Millisecond prescaler
   // ---------------------------------------------------------------------------------------
   logic [PW-1:0] pre_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         pre_q <= '0;
      end else if (pre_q == PRE_LAST) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   assign tick_ms = (pre_q == PRE_LAST);

   // ---------------------------------------------------------------------------------------
   // Switch debounce
   // ---------------------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      opc_debounce #(
         .DEBOUNCE_MS (DEBOUNCE_MS)
      ) u_debounce (
         .clk     (clk),
         .reset_b (reset_b),
         .tick_ms (tick_ms),
         .pin     (sw_i[i]),
         .state   (sw_o[i]),
         .changed (sw_changed[i])
      );
   end

   // ---------------------------------------------------------------------------------------
   // LED drive
   // ---------------------------------------------------------------------------------------
`ifdef OPC_BOARD_PWM_EN
   logic [PWM_BITS-1:0] pwm_q;
   logic                pwm_on;

   assign pwm_on = (pwm_q <= PWM_BITS'(LED_DUTY));

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         pwm_q <= '0;
         led_o <= '0;
      end else begin
         pwm_q <= pwm_q + PWM_BITS'(1);
         led_o <= led_i & {NUM_LED{pwm_on}};
      end
   end
`else
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         led_o <= '0;
      end else begin
         led_o <= led_i;
      end
   end
`endif

endmodule

// File: tb/tb_opc_board_io.sv
// tb_opc_board_io: directed, self-checking bench for opc_board_io.
// Configuration: CLKSPEED=10000 (10 cycles per ms), DEBOUNCE_MS=3, RESET_CYCLES=16.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_opc_board_io;

   logic       clk = 1'b0;
   logic       reset_b = 1'b0;
   logic       btn_reset = 1'b0;
   logic [7:0] sw_i = 8'h00;
   logic [7:0] led_i = 8'h00;
   logic [7:0] sw_o;
   logic [7:0] sw_changed;
   logic [7:0] led_o;
   logic       sys_reset_b;
   logic       tick_ms;

   int n_cmp = 0;
   int n_bad = 0;

   opc_board_io #(
      .CLKSPEED     (10000),
      .NUM_SW       (8),
      .NUM_LED      (8),
      .DEBOUNCE_MS  (3),
      .RESET_CYCLES (16),
      .LED_DUTY     (7)
   ) dut (
      .clk         (clk),
      .reset_b     (reset_b),
      .btn_reset   (btn_reset),
      .sw_i        (sw_i),
      .sw_o        (sw_o),
      .sw_changed  (sw_changed),
      .led_i       (led_i),
      .led_o       (led_o),
      .sys_reset_b (sys_reset_b),
      .tick_ms     (tick_ms)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] led;
      logic [7:0] exp_hold;
      logic [7:0] exp_new;
   } led_vec_t;

   led_vec_t led_tab[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  pulses;
      int  stray;
      bit  found;
      int  ones[8];

      // led_o before each new request holds the previous request (led_i starts at 0).
      led_tab[0] = '{led: 8'hA5, exp_hold: 8'h00, exp_new: 8'hA5};
      led_tab[1] = '{led: 8'h5A, exp_hold: 8'hA5, exp_new: 8'h5A};
      led_tab[2] = '{led: 8'hFF, exp_hold: 8'h5A, exp_new: 8'hFF};
      led_tab[3] = '{led: 8'h00, exp_hold: 8'hFF, exp_new: 8'h00};
      led_tab[4] = '{led: 8'h81, exp_hold: 8'h00, exp_new: 8'h81};
      led_tab[5] = '{led: 8'h3C, exp_hold: 8'h81, exp_new: 8'h3C};

      // ---- Reset state, including an LED request and a held switch during reset
      step(3);
      led_i = 8'hFF;
      step(2);
      check("rst_sys_reset_b", sys_reset_b, 0);
      check("rst_sw_o", sw_o, 0);
      check("rst_sw_changed", sw_changed, 0);
      check("rst_led_o", led_o, 0);
      check("rst_tick_ms", tick_ms, 0);
      led_i = 8'h00;

      // ---- Reset stretch: sys_reset_b rises on the 17th edge after release
      reset_b = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         step(1);
         check("stretch_sys_reset_b", sys_reset_b, (n >= 17));
         check("stretch_tick_ms", tick_ms, (n == 9));
         if (n < 17) check("stretch_sw_o", sw_o, 0);
      end

      // ---- Button: 5-cycle pulse; low from the 3rd edge, high again 18 edges after fall
      btn_reset = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         step(1);
         check("btn_assert", sys_reset_b, (n < 3));
      end
      btn_reset = 1'b0;
      for (int n = 1; n <= 18; n++) begin
         step(1);
         check("btn_release", sys_reset_b, (n >= 18));
      end

      // ---- Debounce accept on sw_i[2]
      sw_i[2] = 1'b1;
      found = 0; lat = 0; pulses = 0; stray = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1);
         if (sw_changed[2]) pulses++;
         if (((sw_changed | sw_o) & 8'hFB) != 8'h00) stray++;
         if (!found && sw_o[2]) begin
            found = 1;
            lat = n;
            check("accept_pulse_align", sw_changed[2], 1);
         end
      end
      check("accept_seen", found, 1);
      check("accept_latency_in_23_33", (lat >= 23 && lat <= 33), 1);
      check("accept_pulse_count", pulses, 1);
      check("accept_other_bits", stray, 0);

      // ---- Bounce reject on sw_i[0]: toggles every 15 cycles for 200 cycles
      found = 0; stray = 0;
      for (int n = 0; n < 200; n++) begin
         if (n % 15 == 0) sw_i[0] = ~sw_i[0];
         step(1);
         if (sw_o[0]) found = 1;
         if (sw_changed != 8'h00) stray++;
      end
      sw_i[0] = 1'b0;
      check("bounce_sw_o0_stays_0", found, 0);
      check("bounce_no_changed", stray, 0);
      check("bounce_sw_o", sw_o, 8'h04);

      // ---- Reset 20 cycles into a debounce of sw_i[5]
      sw_i[5] = 1'b1;
      step(20);
      check("middeb_not_yet", sw_o, 8'h04);
      #1;
      reset_b = 1'b0;
      #1;
      check("middeb_async_sys", sys_reset_b, 0);
      check("middeb_async_sw_o", sw_o, 0);
      step(3);
      check("middeb_sw_o", sw_o, 0);
      check("middeb_sw_changed", sw_changed, 0);
      reset_b = 1'b1;
      found = 0; lat = 0; pulses = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1);
         if (n == 16) check("rerel_sys_low", sys_reset_b, 0);
         if (n == 17) check("rerel_sys_high", sys_reset_b, 1);
         if (sw_changed != 8'h00) pulses++;
         if (!found && sw_o != 8'h00) begin
            found = 1;
            lat = n;
            check("rerel_sw_o", sw_o, 8'h24);
            check("rerel_sw_changed", sw_changed, 8'h24);
         end
      end
      check("rerel_seen", found, 1);
      check("rerel_latency_le_33", (lat >= 23 && lat <= 33), 1);
      check("rerel_pulse_cycles", pulses, 1);

      // ---- Release sw_i[5]: falling change is debounced and pulsed too
      sw_i[5] = 1'b0;
      found = 0; pulses = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1);
         if (sw_changed[5]) pulses++;
         if (sw_changed[2]) pulses += 100;
         if (!found && !sw_o[5]) begin
            found = 1;
            check("fall_pulse_align", sw_changed[5], 1);
         end
      end
      check("fall_seen", found, 1);
      check("fall_pulse_count", pulses, 1);
      check("fall_sw_o", sw_o, 8'h04);

`ifdef OPC_BOARD_PWM_EN
      // ---- PWM: each bit on for 8 of every 16 cycles, all bits in step
      led_i = 8'hFF;
      step(2);
      for (int b = 0; b < 8; b++) ones[b] = 0;
      stray = 0;
      for (int n = 0; n < 16; n++) begin
         step(1);
         for (int b = 0; b < 8; b++) if (led_o[b]) ones[b]++;
         if (led_o != 8'h00 && led_o != 8'hFF) stray++;
      end
      for (int b = 0; b < 8; b++) check("pwm_on_cycles", ones[b], 8);
      check("pwm_bits_in_step", stray, 0);
`else
      // ---- LED: led_o follows led_i one cycle later
      for (int b = 0; b < 8; b++) ones[b] = 0;
      for (int v = 0; v < 6; v++) begin
         led_i = led_tab[v].led;
         check("led_hold", led_o, led_tab[v].exp_hold);
         step(1);
         check("led_new", led_o, led_tab[v].exp_new);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
